// File: rtl/vector_subtraction_pipe_if.sv
// vector_subtraction_pipe_if: valid/ready operand and result bundle for the vector subtractor.
interface vector_subtraction_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [56:0] in_vector_1;
    logic [56:0] in_vector_2;
    logic        out_valid;
    logic        out_ready;
    logic [56:0] out_vector;
    logic [2:0]  out_ovf;
    logic [7:0]  ovf_count;
    modport master (
        output in_valid, in_vector_1, in_vector_2, out_ready,
        input  in_ready, out_valid, out_vector, out_ovf, ovf_count
    );
    modport slave (
        input  in_valid, in_vector_1, in_vector_2, out_ready,
        output in_ready, out_valid, out_vector, out_ovf, ovf_count
    );
endinterface

// File: rtl/vector_subtraction_pipe.sv
// vector_subtraction_pipe: two-stage valid/ready {x,y,z} subtractor with per-component overflow.
// Define VSUB_SATURATE_EN to clamp overflowing components instead of wrapping.
module vector_subtraction_pipe (
    input logic clk,
    input logic rst,
    vector_subtraction_pipe_if.slave bus
);
    localparam int VECTOR_WIDTH = 57;
    localparam int COMP_WIDTH = 19;
    logic adv1, adv2;
    logic s1_valid_q, s1_valid_d;
    logic [2:0][COMP_WIDTH:0] s1_diff_q, s1_diff_d;
    logic out_valid_q, out_valid_d;
    logic [VECTOR_WIDTH-1:0] out_vector_q, out_vector_d;
    logic [2:0] out_ovf_q, out_ovf_d;
    logic [7:0] ovf_count_q, ovf_count_d;
    function automatic logic [COMP_WIDTH:0] sext(input logic [COMP_WIDTH-1:0] v);
        return {v[COMP_WIDTH-1], v};
    endfunction
    always_comb begin
        adv2 = !out_valid_q || bus.out_ready;
        adv1 = !s1_valid_q || adv2;
        s1_valid_d = adv1 ? bus.in_valid : s1_valid_q;
        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        s1_diff_d = s1_diff_q;
        out_vector_d = out_vector_q;
        out_ovf_d = out_ovf_q;
        for (int i = 0; i < 3; i++) begin
            if (adv1 && bus.in_valid)
                s1_diff_d[i] = sext(bus.in_vector_1[i*COMP_WIDTH +: COMP_WIDTH])
                             - sext(bus.in_vector_2[i*COMP_WIDTH +: COMP_WIDTH]);
            if (adv2 && s1_valid_q) begin
                out_ovf_d[i] = s1_diff_q[i][COMP_WIDTH] != s1_diff_q[i][COMP_WIDTH-1];
`ifdef VSUB_SATURATE_EN
                out_vector_d[i*COMP_WIDTH +: COMP_WIDTH] = !out_ovf_d[i] ? s1_diff_q[i][COMP_WIDTH-1:0]
                                                         : s1_diff_q[i][COMP_WIDTH] ? 19'h40000 : 19'h3FFFF;
`else
                out_vector_d[i*COMP_WIDTH +: COMP_WIDTH] = s1_diff_q[i][COMP_WIDTH-1:0];
`endif
            end
        end
        ovf_count_d = (out_valid_q && bus.out_ready && |out_ovf_q && ovf_count_q != 8'hFF)
                    ? ovf_count_q + 8'd1 : ovf_count_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_diff_q    <= '0;
            out_valid_q  <= 1'b0;
            out_vector_q <= '0;
            out_ovf_q    <= '0;
            ovf_count_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_diff_q    <= s1_diff_d;
            out_valid_q  <= out_valid_d;
            out_vector_q <= out_vector_d;
            out_ovf_q    <= out_ovf_d;
            ovf_count_q  <= ovf_count_d;
        end
    end
    assign bus.in_ready   = adv1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_vector = out_vector_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.ovf_count  = ovf_count_q;
endmodule

// File: tb/tb_vector_subtraction_pipe.sv
// tb_vector_subtraction_pipe: directed and model-checked tests for vector_subtraction_pipe.
module tb_vector_subtraction_pipe;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    vector_subtraction_pipe_if bus();
    vector_subtraction_pipe dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [18:0] comp_sub(input logic [18:0] a, input logic [18:0] b, output logic ovf);
        int da = $signed(a);
        int db = $signed(b);
        int d = da - db;
        ovf = (d > 262143) || (d < -262144);
`ifdef VSUB_SATURATE_EN
        if (ovf) return (d > 0) ? 19'h3FFFF : 19'h40000;
`endif
        return d[18:0];
    endfunction

    function automatic logic [56:0] vec_sub(input logic [56:0] a, input logic [56:0] b, output logic [2:0] ovf);
        logic [56:0] r;
        r[56:38] = comp_sub(a[56:38], b[56:38], ovf[2]);
        r[37:19] = comp_sub(a[37:19], b[37:19], ovf[1]);
        r[18:0]  = comp_sub(a[18:0], b[18:0], ovf[0]);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_vector_1 = '0;
        bus.in_vector_2 = '0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_vector !== 57'd0) begin errors++; $display("FAIL reset_out_vector got %h want 0", bus.out_vector); end
        checks++; if (bus.out_ovf !== 3'd0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", bus.out_ovf); end
        checks++; if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf_count got %0d want 0", bus.ovf_count); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_vector_1 = {19'h00C00, 19'h00000, 19'h00600};
        bus.in_vector_2 = {19'h00400, 19'h00200, 19'h00600};
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", bus.out_valid); end
        checks++; if (bus.out_vector !== {19'h00800, 19'h7FE00, 19'h00000}) begin errors++; $display("FAIL basic_vector got %h want %h", bus.out_vector, {19'h00800, 19'h7FE00, 19'h00000}); end
        checks++; if (bus.out_ovf !== 3'b000) begin errors++; $display("FAIL basic_ovf got %b want 000", bus.out_ovf); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_result got %b want 0", bus.out_valid); end
        checks++; if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL basic_ovf_count got %0d want 0", bus.ovf_count); end
    endtask

    task automatic test_overflow();
        logic [56:0] a [2];
        logic [56:0] b [2];
        logic [56:0] e [2];
        a[0] = {19'h40000, 19'h00000, 19'h00000};
        b[0] = {19'h00400, 19'h00000, 19'h00000};
        a[1] = {19'h3FC00, 19'h00000, 19'h00000};
        b[1] = {19'h7F800, 19'h00000, 19'h00000};
`ifdef VSUB_SATURATE_EN
        e[0] = {19'h40000, 19'h00000, 19'h00000};
        e[1] = {19'h3FFFF, 19'h00000, 19'h00000};
`else
        e[0] = {19'h3FC00, 19'h00000, 19'h00000};
        e[1] = {19'h40400, 19'h00000, 19'h00000};
`endif
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.out_ready = 1'b1;
            bus.in_vector_1 = a[k];
            bus.in_vector_2 = b[k];
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovf%0d_valid got %b want 1", k, bus.out_valid); end
            checks++; if (bus.out_vector !== e[k]) begin errors++; $display("FAIL ovf%0d_vector got %h want %h", k, bus.out_vector, e[k]); end
            checks++; if (bus.out_ovf !== 3'b100) begin errors++; $display("FAIL ovf%0d_flags got %b want 100", k, bus.out_ovf); end
            exp_cnt++;
            @(negedge clk);
            checks++; if (bus.ovf_count !== 8'(exp_cnt)) begin errors++; $display("FAIL ovf%0d_count got %0d want %0d", k, bus.ovf_count, exp_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        logic [56:0] e;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                e = {19'(19'h00100 * (k - 2)), 19'h7FFF0, 19'h00000};
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid got %b want 1", k - 2, bus.out_valid); end
                checks++; if (bus.out_vector !== e) begin errors++; $display("FAIL b2b%0d_vector got %h want %h", k - 2, bus.out_vector, e); end
            end
            bus.out_ready = 1'b1;
            bus.in_valid = (k <= 3);
            bus.in_vector_1 = {19'(19'h00100 * k), 19'h00010, 19'h00000};
            bus.in_vector_2 = {19'h00000, 19'h00020, 19'h00000};
        end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [56:0] exp_q [$];
        logic [2:0] ovf_q [$];
        logic [56:0] va, vb, ev;
        logic [2:0] eo;
        int sent = 0, received = 0, inflight = 0, cyc = 0;
        logic fire_in, fire_out, exp_rdy;
        while (received < 10 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            va = {$urandom, $urandom};
            vb = {$urandom, $urandom};
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid = (sent < 10);
            bus.in_vector_1 = va;
            bus.in_vector_2 = vb;
            #1;
            exp_rdy = !(inflight == 2 && !bus.out_ready);
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, bus.in_ready, exp_rdy); end
            fire_in = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_unexpected got %h want none", bus.out_vector); end
                else begin
                    ev = exp_q.pop_front();
                    eo = ovf_q.pop_front();
                    if (bus.out_vector !== ev || bus.out_ovf !== eo) begin
                        errors++;
                        $display("FAIL bp_result%0d got %h/%b want %h/%b", received, bus.out_vector, bus.out_ovf, ev, eo);
                    end
                    if (|eo && exp_cnt < 255) exp_cnt++;
                end
                received++;
                inflight--;
            end
            if (fire_in) begin
                exp_q.push_back(vec_sub(va, vb, eo));
                ovf_q.push_back(eo);
                sent++;
                inflight++;
            end
        end
        checks++; if (received != 10) begin errors++; $display("FAIL bp_timeout got %0d want 10", received); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (bus.ovf_count !== 8'(exp_cnt)) begin errors++; $display("FAIL bp_ovf_count got %0d want %0d", bus.ovf_count, exp_cnt); end
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate got %b want 0", bus.out_valid); end
    endtask

    task automatic test_counter_saturation();
        int accepted = 0, cyc = 0;
        while (accepted < 300 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = 1'b1;
            bus.out_ready = 1'b1;
            bus.in_vector_1 = {19'h40000, 19'h00000, 19'h00000};
            bus.in_vector_2 = {19'h00400, 19'h00000, 19'h00000};
            #1;
            if (bus.in_ready) accepted++;
        end
        checks++; if (accepted != 300) begin errors++; $display("FAIL sat_timeout got %0d want 300", accepted); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        exp_cnt = 255;
        checks++; if (bus.ovf_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d want 255", bus.ovf_count); end
        repeat (3) @(negedge clk);
        checks++; if (bus.ovf_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", bus.ovf_count); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_vector_1 = {19'h3FC00, 19'h00400, 19'h00000};
        bus.in_vector_2 = {19'h7F800, 19'h00000, 19'h00000};
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_full_ready got %b want 0", bus.in_ready); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_vector !== 57'd0) begin errors++; $display("FAIL mid_out_vector got %h want 0", bus.out_vector); end
        checks++; if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL mid_ovf_count got %0d want 0", bus.ovf_count); end
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", bus.in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got %b want 0", k, bus.out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_counter_saturation();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
